// File: rtl/uart_hex_dump_pkg.sv
// rtl/uart_hex_dump_pkg.sv - shared constants, FSM encoding and hex helper for the hex dumper
package uart_hex_dump_pkg;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        SEP,
        SEP2,
        WAIT
    } state_t;

    // Uppercase ASCII: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/uart_hex_dump_if.sv
// rtl/uart_hex_dump_if.sv - character link between the hex dumper and the UART transmitter
interface uart_hex_dump_if;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;

    modport master (output tx_dv, output tx_byte, input tx_active, input tx_done);
    modport slave  (input tx_dv, input tx_byte, output tx_active, output tx_done);
endinterface

// File: rtl/uart_hex_dump_byte_fifo.sv
// rtl/uart_hex_dump_byte_fifo.sv - byte FIFO with wrap-around pointers and occupancy output
module byte_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [7:0]   din,
    input  logic         pop,
    output logic [7:0]   dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // The extra pointer bit distinguishes full from empty
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_hex_dump.sv
// rtl/uart_hex_dump.sv - buffers USB bytes and streams them to the debug UART as hex text
module uart_hex_dump
    import uart_hex_dump_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int BYTES_PER_LINE = 16
) (
    input  logic                     clk_48,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    input  logic                     clear,
    uart_hex_dump_if.master          tx,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam logic [7:0] LAST_COL = 8'(BYTES_PER_LINE - 1);

    state_t     state;
    state_t     ret;
    logic [7:0] hold;
    logic [7:0] column;
    logic [7:0] head;
    logic       full;
    logic       empty;
    logic       pop;

    // The transmitter is never reset, so a new byte only starts once it is idle
    assign pop = (state == IDLE) && !empty && !tx.tx_active;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_48),
        .rst_n (rst_n),
        .push  (in_valid),
        .din   (in_data),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ret        <= IDLE;
            hold       <= '0;
            column     <= '0;
            overflow   <= 1'b0;
            tx.tx_dv   <= 1'b0;
            tx.tx_byte <= '0;
        end else begin
            tx.tx_dv <= 1'b0;

            if (clear)                 overflow <= 1'b0;
            else if (in_valid && full) overflow <= 1'b1;

            case (state)
                IDLE: if (pop) begin
                    hold  <= head;
                    state <= HI;
                end
                HI: begin
                    tx.tx_byte <= hex_ascii(hold[7:4]);
                    tx.tx_dv   <= 1'b1;
                    ret        <= LO;
                    state      <= WAIT;
                end
                LO: begin
                    tx.tx_byte <= hex_ascii(hold[3:0]);
                    tx.tx_dv   <= 1'b1;
                    ret        <= SEP;
                    state      <= WAIT;
                end
                SEP: begin
                    if (column == LAST_COL) begin
                        tx.tx_byte <= ASCII_CR;
                        column     <= '0;
                        ret        <= SEP2;
                    end else begin
                        tx.tx_byte <= ASCII_SP;
                        column     <= column + 8'd1;
                        ret        <= IDLE;
                    end
                    tx.tx_dv <= 1'b1;
                    state    <= WAIT;
                end
                SEP2: begin
                    tx.tx_byte <= ASCII_LF;
                    tx.tx_dv   <= 1'b1;
                    ret        <= IDLE;
                    state      <= WAIT;
                end
                WAIT: if (tx.tx_done) state <= ret;
                default: state <= IDLE;
            endcase

            // Placed last so a clear overrides the separator's column update
            if (clear) column <= '0;
        end
    end

endmodule

// File: doc/uart_hex_dump.md
Name: uart_hex_dump

Overview:
- Upstream feeder for the debug UART transmitter.
- Captures raw bytes from the USB core's data strobe into a small FIFO.
- Converts each byte to uppercase ASCII hex with separators and line breaks.
- Drives the transmitter's data-valid/byte inputs and paces itself on the transmitter's active/done outputs, so USB traffic can be dumped to a serial terminal without dropping bytes under normal rates.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of 2, minimum 4.
- BYTES_PER_LINE, 16, bytes per text line; range 1..255.

Ports:
- clk_48  in  1  48 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  byte to dump (USB data_out)
- in_valid  in  1  one-cycle strobe, in_data valid (USB data_strobe)
- clear  in  1  synchronous; clears overflow flag and resets line column counter
- tx_dv  out  1  one-cycle pulse to transmitter, tx_byte valid
- tx_byte  out  8  ASCII character to transmit
- tx_active  in  1  transmitter busy
- tx_done  in  1  transmitter one-cycle completion pulse
- overflow  out  1  sticky: at least one input byte dropped
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset state:
  - tx_dv=0, tx_byte=8'h00, overflow=0, level=0.
  - FIFO empty, column=0, FSM=IDLE.
  - The transmitter has no reset, so the FSM never issues tx_dv while tx_active=1.
- FIFO push:
  - in_valid and not full: in_data is written and level increments the next cycle.
  - in_valid and full: byte dropped, overflow set next cycle. Fullness is evaluated before any same-cycle pop, so a push at full is dropped even if a pop occurs that cycle.
  - Push and pop in the same cycle, not full: level unchanged.
- FSM states: IDLE, HI, LO, SEP, SEP2, WAIT.
  - IDLE: if FIFO not empty and tx_active=0, pop the head into a holding register and go to HI.
  - HI: tx_byte=hex(hold[7:4]), tx_dv=1 for one cycle, ret=LO, go to WAIT.
  - LO: tx_byte=hex(hold[3:0]), tx_dv=1, ret=SEP, go to WAIT.
  - SEP:
    - If column==BYTES_PER_LINE-1: tx_byte=8'h0D, column=0, ret=SEP2.
    - Else: tx_byte=8'h20, column+1, ret=IDLE.
    - Either way tx_dv=1, go to WAIT.
  - SEP2: tx_byte=8'h0A, tx_dv=1, ret=IDLE, go to WAIT.
  - WAIT: on tx_done=1, go to ret. Ignore tx_active.
- Hex mapping: 0-9 -> 8'h30-8'h39, A-F -> 8'h41-8'h46.
- tx_byte holds its value until the next tx_dv.
- Latency: for a byte strobed into an empty FIFO at cycle t (transmitter idle), the first tx_dv occurs at t+3 (t+1 write visible, t+2 pop in IDLE, t+3 HI).
- clear:
  - Same cycle as an overflow drop: clear wins, overflow=0.
  - Column reset takes effect immediately. If asserted mid-byte, the current byte's remaining characters still complete.
- Reset mid-character: tx_dv deasserts immediately and FIFO contents are lost. After reset release, the FSM waits in IDLE until tx_active=0.
- level saturates at DEPTH; pointer widths are $clog2(DEPTH)+1 with wrap-around.

Decomposition:
- Shared package:
  - ASCII constants: ASCII_SP=8'h20, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - FSM state encoding.
  - hex-nibble-to-ASCII function.
- Sub-module: byte_fifo (DEPTH param; push, pop, dout, full, empty, level; asynchronous active-low reset). The formatter FSM stays in uart_hex_dump.

Test Plan:
- Single byte 8'hA5 with transmitter model (tx_active high 10 cycles after each tx_dv, then tx_done pulse):
  - tx sequence 8'h41, 8'h35, 8'h20; first tx_dv exactly 3 cycles after in_valid.
- BYTES_PER_LINE=4, bytes 00,01,02,03:
  - "00 01 02 0" then "3", 8'h0D, 8'h0A; column back to 0.
  - Fifth byte 8'hFF gives "FF ".
- DEPTH=4, transmitter stalled (tx_active=1, no tx_done), 6 strobes:
  - level=4, overflow=1 after 5th strobe; bytes 5 and 6 absent from the later output.
  - clear drops overflow to 0.
- Transmitter with tx_active=1 at reset release: no tx_dv until tx_active=0, even with FIFO non-empty.
- Async reset asserted while in WAIT after the HI character of 8'h3C:
  - tx_dv=0 and level=0 immediately.
  - After release, new byte 8'h7E yields "7E " with no leftover "C".
- Push and pop in the same cycle at level=2: level stays 2 and byte order is preserved in the output.
